// File: rtl/id_exe_ctrl.sv
// ---------------------------------------------------------------------------
// id_exe_ctrl
//
// Decode-side producer of the EXE-stage control word for the ARM-subset ALU.
// Decodes the instruction class, opcode, S bit and condition field, holds the
// NZCV status register, evaluates the condition against it (with a bypass of
// the flags being written this cycle) and registers the resulting control
// signals as the ID/EX control pipeline slice, with stall and flush.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   id_valid     decode slot holds a real instruction
//   mode         00 data-processing, 01 memory, 10 branch, 11 illegal
//   opcode       ARM data-processing opcode field
//   s_in         S bit; for memory ops 1 = LDR, 0 = STR
//   cond         ARM condition field
//   flags_in     NZCV produced by the ALU in EXE
//   sr_we        load flags_in into the status register
//   stall        hold the ID/EX control slice
//   flush        replace the ID/EX control slice with a bubble
//   exe_cmd      ALU command
//   exe_wb_en    register writeback enable
//   exe_mem_r    memory read
//   exe_mem_w    memory write
//   exe_b        branch taken
//   exe_s        update flags in EXE
//   exe_valid    slice holds a live instruction
//   exe_illegal  slice holds an illegal / undecodable instruction
//   carry_c      status-register C bit (ALU carry input)
//   sr_q         current NZCV
// ---------------------------------------------------------------------------
module id_exe_ctrl #(
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s_in,
    input  logic [3:0]       cond,
    input  logic [3:0]       flags_in,
    input  logic             sr_we,
    input  logic             stall,
    input  logic             flush,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             exe_wb_en,
    output logic             exe_mem_r,
    output logic             exe_mem_w,
    output logic             exe_b,
    output logic             exe_s,
    output logic             exe_valid,
    output logic             exe_illegal,
    output logic             carry_c,
    output logic [3:0]       sr_q
);

    localparam logic [CMD_W-1:0] CMD_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;

    logic [3:0]       r_sr;
    logic [CMD_W-1:0] r_cmd;
    logic             r_wb;
    logic             r_memR;
    logic             r_memW;
    logic             r_b;
    logic             r_s;
    logic             r_valid;
    logic             r_illegal;

    logic [3:0]       w_flags;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_condOk;
    logic [CMD_W-1:0] w_cmd;
    logic             w_wb;
    logic             w_memR;
    logic             w_memW;
    logic             w_b;
    logic             w_s;
    logic             w_illegal;
    logic             w_kill;

    // Status register: updated whenever EXE asks, independent of the slice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= 4'b0000;
        end else if (sr_we) begin
            r_sr <= flags_in;
        end
    end

    // Flags being written this cycle are visible to the condition check.
    assign w_flags = sr_we ? flags_in : r_sr;
    assign w_n     = w_flags[3];
    assign w_z     = w_flags[2];
    assign w_c     = w_flags[1];
    assign w_v     = w_flags[0];

    always_comb begin
        w_condOk = 1'b0;
        case (cond)
            4'b0000: w_condOk = w_z;
            4'b0001: w_condOk = !w_z;
            4'b0010: w_condOk = w_c;
            4'b0011: w_condOk = !w_c;
            4'b0100: w_condOk = w_n;
            4'b0101: w_condOk = !w_n;
            4'b0110: w_condOk = w_v;
            4'b0111: w_condOk = !w_v;
            4'b1000: w_condOk = w_c && !w_z;
            4'b1001: w_condOk = !w_c || w_z;
            4'b1010: w_condOk = (w_n == w_v);
            4'b1011: w_condOk = (w_n != w_v);
            4'b1100: w_condOk = !w_z && (w_n == w_v);
            4'b1101: w_condOk = w_z || (w_n != w_v);
            4'b1110: w_condOk = 1'b1;
            default: w_condOk = 1'b0;
        endcase
    end

    // Instruction decode. CMP and TST reuse the SUB/AND datapath but never
    // write back and always set flags, otherwise they would be no-ops.
    always_comb begin
        w_cmd     = CMD_NOP;
        w_wb      = 1'b0;
        w_memR    = 1'b0;
        w_memW    = 1'b0;
        w_b       = 1'b0;
        w_s       = 1'b0;
        w_illegal = 1'b0;
        case (mode)
            2'b00: begin
                w_s  = s_in;
                w_wb = 1'b1;
                case (opcode)
                    4'b1101: w_cmd = CMD_MOV;
                    4'b1111: w_cmd = CMD_MVN;
                    4'b0100: w_cmd = CMD_ADD;
                    4'b0101: w_cmd = CMD_ADC;
                    4'b0010: w_cmd = CMD_SUB;
                    4'b0110: w_cmd = CMD_SBC;
                    4'b0000: w_cmd = CMD_AND;
                    4'b1100: w_cmd = CMD_ORR;
                    4'b0001: w_cmd = CMD_EOR;
                    4'b1010: begin
                        w_cmd = CMD_SUB;
                        w_wb  = 1'b0;
                        w_s   = 1'b1;
                    end
                    4'b1000: begin
                        w_cmd = CMD_AND;
                        w_wb  = 1'b0;
                        w_s   = 1'b1;
                    end
                    default: begin
                        w_wb      = 1'b0;
                        w_s       = 1'b0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            2'b01: begin
                if (opcode == 4'b0100) begin
                    w_cmd  = CMD_ADD;
                    w_memR = s_in;
                    w_wb   = s_in;
                    w_memW = !s_in;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            2'b10: begin
                w_b = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_kill = !id_valid || !w_condOk || w_illegal;

    // ID/EX control slice: flush beats stall; a killed instruction becomes a
    // bubble that only remembers whether it was a live illegal instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd     <= CMD_NOP;
            r_wb      <= 1'b0;
            r_memR    <= 1'b0;
            r_memW    <= 1'b0;
            r_b       <= 1'b0;
            r_s       <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_cmd     <= CMD_NOP;
            r_wb      <= 1'b0;
            r_memR    <= 1'b0;
            r_memW    <= 1'b0;
            r_b       <= 1'b0;
            r_s       <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            r_cmd     <= w_kill ? CMD_NOP : w_cmd;
            r_wb      <= w_wb && !w_kill;
            r_memR    <= w_memR && !w_kill;
            r_memW    <= w_memW && !w_kill;
            r_b       <= w_b && !w_kill;
            r_s       <= w_s && !w_kill;
            r_valid   <= !w_kill;
            r_illegal <= id_valid && w_condOk && w_illegal;
        end
    end

    assign exe_cmd     = r_cmd;
    assign exe_wb_en   = r_wb;
    assign exe_mem_r   = r_memR;
    assign exe_mem_w   = r_memW;
    assign exe_b       = r_b;
    assign exe_s       = r_s;
    assign exe_valid   = r_valid;
    assign exe_illegal = r_illegal;
    assign carry_c     = r_sr[1];
    assign sr_q        = r_sr;

endmodule

// File: tb/tb_id_exe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_exe_ctrl
//
// Self-checking bench for id_exe_ctrl. A behavioural model (opcode table,
// condition evaluated as base-predicate-plus-inversion, slice/status state)
// tracks the expected outputs; directed scenarios add fixed expectations.
// ---------------------------------------------------------------------------
module tb_id_exe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] opcode = 4'b0000;
    logic       s_in = 1'b0;
    logic [3:0] cond = 4'b1110;
    logic [3:0] flags_in = 4'b0000;
    logic       sr_we = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    logic [3:0] exe_cmd;
    logic       exe_wb_en;
    logic       exe_mem_r;
    logic       exe_mem_w;
    logic       exe_b;
    logic       exe_s;
    logic       exe_valid;
    logic       exe_illegal;
    logic       carry_c;
    logic [3:0] sr_q;

    int checks = 0;
    int errors = 0;

    // Model state: expected slice {cmd, wb, memR, memW, b, s, valid, illegal}.
    logic [10:0] mSlice = '0;
    logic [3:0]  mSr = '0;

    // ALU command per data-processing opcode; zero marks an illegal opcode.
    logic [3:0] opCmd [16] = '{4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
                               4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};

    wire [10:0] dutSlice = {exe_cmd, exe_wb_en, exe_mem_r, exe_mem_w,
                            exe_b, exe_s, exe_valid, exe_illegal};

    id_exe_ctrl #(.CMD_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .mode(mode),
        .opcode(opcode),
        .s_in(s_in),
        .cond(cond),
        .flags_in(flags_in),
        .sr_we(sr_we),
        .stall(stall),
        .flush(flush),
        .exe_cmd(exe_cmd),
        .exe_wb_en(exe_wb_en),
        .exe_mem_r(exe_mem_r),
        .exe_mem_w(exe_mem_w),
        .exe_b(exe_b),
        .exe_s(exe_s),
        .exe_valid(exe_valid),
        .exe_illegal(exe_illegal),
        .carry_c(carry_c),
        .sr_q(sr_q)
    );

    always #5 clk = ~clk;

    // Condition: odd codes are the inverse of the even code below them.
    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    // Expected next slice for the current inputs.
    function automatic logic [10:0] refDecode();
        logic [3:0] f;
        logic [3:0] cmd;
        logic wb, mr, mw, b, s, legal, ok;
        f = sr_we ? flags_in : mSr;
        ok = condHolds(cond, f);
        cmd = 4'h0; wb = 0; mr = 0; mw = 0; b = 0; s = 0; legal = 1;
        if (mode == 2'b00) begin
            cmd = opCmd[opcode];
            legal = (cmd != 4'h0);
            if (opcode == 4'hA || opcode == 4'h8) begin
                s = 1;
            end else begin
                wb = 1;
                s = s_in;
            end
        end else if (mode == 2'b01) begin
            legal = (opcode == 4'h4);
            cmd = 4'h2;
            mr = s_in;
            wb = s_in;
            mw = ~s_in;
        end else if (mode == 2'b10) begin
            b = 1;
        end else begin
            legal = 0;
        end
        if (!id_valid || !ok) return 11'd0;
        if (!legal) return 11'd1;
        return {cmd, wb, mr, mw, b, s, 1'b1, 1'b0};
    endfunction

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        logic [10:0] nxt;
        nxt = refDecode();
        @(posedge clk);
        if (flush) mSlice = '0;
        else if (!stall) mSlice = nxt;
        if (sr_we) mSr = flags_in;
        #1;
    endtask

    task automatic setInstr(input logic [1:0] m, input logic [3:0] op,
                            input logic s, input logic [3:0] c);
        id_valid = 1'b1;
        mode = m;
        opcode = op;
        s_in = s;
        cond = c;
    endtask

    task automatic test_reset();
        setInstr(2'b00, 4'h4, 1'b0, 4'hE);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dutSlice !== 11'd0 || sr_q !== 4'h0 || carry_c !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc%0d slice=%h sr=%h c=%b want 0", i, dutSlice, sr_q, carry_c);
            end
        end
        mSlice = '0;
        mSr = '0;
        rst = 1'b1;
        tick();
        checks++;
        if (dutSlice !== {4'b0010, 7'b1000010}) begin
            errors++;
            $display("[TB] FAIL reset_release slice=%h want %h", dutSlice, {4'b0010, 7'b1000010});
        end
    endtask

    task automatic test_decode_sweep();
        logic [17:0] sweep [16] = '{
            18'b00_1101_0_0001_1000010, 18'b00_1111_0_1001_1000010,
            18'b00_0100_0_0010_1000010, 18'b00_0101_0_0011_1000010,
            18'b00_0010_0_0100_1000010, 18'b00_0110_0_0101_1000010,
            18'b00_0000_0_0110_1000010, 18'b00_1100_0_0111_1000010,
            18'b00_0001_0_1000_1000010, 18'b00_1010_0_0100_0000110,
            18'b00_1000_0_0110_0000110, 18'b01_0100_1_0010_1100010,
            18'b01_0100_0_0010_0010010, 18'b00_1011_0_0000_0000001,
            18'b10_0000_0_0000_0001010, 18'b11_0100_0_0000_0000001};
        logic [17:0] e;
        sr_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = sweep[i];
            setInstr(e[17:16], e[15:12], e[11], 4'hE);
            tick();
            checks++;
            if (dutSlice !== e[10:0] || dutSlice !== mSlice) begin
                errors++;
                $display("[TB] FAIL sweep[%0d] slice=%h want %h model %h", i, dutSlice, e[10:0], mSlice);
            end
        end
    endtask

    task automatic test_cond_bypass();
        // Clear status with a never-executed instruction.
        setInstr(2'b00, 4'h4, 1'b0, 4'hF);
        sr_we = 1'b1; flags_in = 4'h0;
        tick();
        setInstr(2'b00, 4'h4, 1'b0, 4'h0);
        sr_we = 1'b1; flags_in = 4'b0100;
        tick();
        checks++;
        if (exe_valid !== 1'b1 || exe_wb_en !== 1'b1 || sr_q !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL bypass_on valid=%b wb=%b sr=%h want 1 1 4", exe_valid, exe_wb_en, sr_q);
        end
        setInstr(2'b00, 4'h4, 1'b0, 4'hF);
        sr_we = 1'b1; flags_in = 4'h0;
        tick();
        setInstr(2'b00, 4'h4, 1'b0, 4'h0);
        sr_we = 1'b0; flags_in = 4'b0100;
        tick();
        checks++;
        if (exe_valid !== 1'b0 || dutSlice !== 11'd0) begin
            errors++;
            $display("[TB] FAIL bypass_off slice=%h want 000", dutSlice);
        end
    endtask

    task automatic test_signed_cond();
        logic [3:0] conds [6] = '{4'hA, 4'hB, 4'hC, 4'hC, 4'hD, 4'hF};
        logic [3:0] srs   [6] = '{4'h9, 4'h9, 4'h9, 4'hD, 4'hD, 4'hD};
        logic       live  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            setInstr(2'b00, 4'h4, 1'b0, 4'hF);
            sr_we = 1'b1; flags_in = srs[i];
            tick();
            sr_we = 1'b0; flags_in = 4'h0;
            setInstr(2'b00, 4'h4, 1'b0, conds[i]);
            tick();
            checks++;
            if (exe_valid !== live[i] || dutSlice !== mSlice) begin
                errors++;
                $display("[TB] FAIL signed[%0d] cond=%h sr=%h valid=%b want %b", i, conds[i], sr_q, exe_valid, live[i]);
            end
        end
    endtask

    task automatic test_stall_flush();
        setInstr(2'b00, 4'h4, 1'b0, 4'hE);
        tick();
        setInstr(2'b00, 4'h2, 1'b0, 4'hE);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (exe_cmd !== 4'b0010 || exe_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d cmd=%h valid=%b want 2 1", i, exe_cmd, exe_valid);
            end
        end
        flush = 1'b1;
        tick();
        checks++;
        if (exe_cmd !== 4'b0000 || exe_valid !== 1'b0 || dutSlice !== 11'd0) begin
            errors++;
            $display("[TB] FAIL stall_flush slice=%h want 000", dutSlice);
        end
        flush = 1'b0;
        stall = 1'b0;
        // Reset while a live instruction is stalled: it must be lost.
        setInstr(2'b00, 4'h4, 1'b0, 4'hE);
        tick();
        stall = 1'b1;
        #2 rst = 1'b0;
        #1;
        mSlice = '0;
        mSr = '0;
        checks++;
        if (dutSlice !== 11'd0 || sr_q !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_midstall slice=%h sr=%h want 0", dutSlice, sr_q);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (dutSlice !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_after slice=%h want 000", dutSlice);
        end
        stall = 1'b0;
    endtask

    task automatic test_carry();
        setInstr(2'b00, 4'h4, 1'b0, 4'hE);
        sr_we = 1'b1; flags_in = 4'b0010;
        tick();
        sr_we = 1'b0; flags_in = 4'h0;
        checks++;
        if (carry_c !== 1'b1 || sr_q !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL carry c=%b sr=%h want 1 2", carry_c, sr_q);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
            opcode = 4'($urandom_range(0, 15));
            if (mode == 2'b01 && $urandom_range(0, 1) == 1) opcode = 4'h4;
            s_in = 1'($urandom_range(0, 1));
            cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            flags_in = 4'($urandom_range(0, 15));
            sr_we = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (dutSlice !== mSlice || sr_q !== mSr || carry_c !== mSr[1]) begin
                errors++;
                $display("[TB] FAIL random%0d slice=%h sr=%h c=%b want %h %h %b", i, dutSlice, sr_q, carry_c, mSlice, mSr, mSr[1]);
            end
        end
        stall = 1'b0;
        flush = 1'b0;
        sr_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_cond_bypass();
        test_signed_cond();
        test_stall_flush();
        test_carry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against the run never reaching its end.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
